seq_stage_controller: RTL and testbench

//  Sequences the single-cycle-per-stage SEQ datapath: Fetch, Decode, Execute, Memory, Writeback, PC update.

---
 rtl/y86_pkg.sv | 25 ++
 rtl/seq_mem_wait_timer.sv | 19 +
 rtl/seq_stage_controller.sv | 97 +++++++++
 tb/tb_seq_stage_controller.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icode and status constants, SEQ stage states and icode helpers
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WB, ST_PCUPD, ST_HALT
  } stage_t;
  function automatic logic is_mem_icode(input logic [3:0] i_icode);
    return i_icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
  endfunction
endpackage

// File: rtl/seq_mem_wait_timer.sv
// seq_mem_wait_timer: counts memory wait cycles, flags the last allowed one
module seq_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end
  assign o_expired = r_cnt == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/seq_stage_controller.sv
// seq_stage_controller: SEQ stage sequencer owning PC, status and run counters
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter int              PC_W        = 64,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              CNT_W       = 32,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ready,
  input  logic             dmem_error,
  input  logic [PC_W-1:0]  pc_next_in,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             wb_en,
  output logic             pcupd_en,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);
  stage_t           r_state, w_next;
  logic [2:0]       r_stat, w_stat;
  logic [3:0]       r_icode;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cycles, r_instrs;
  logic             w_mem_op, w_expired, w_busy;
  assign w_mem_op = is_mem_icode(r_icode);
  assign w_busy   = r_state != ST_IDLE && r_state != ST_HALT;
  seq_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state != ST_MEMORY),
    .i_inc    (r_state == ST_MEMORY && w_mem_op && !mem_ready),
    .o_expired(w_expired)
  );
  always_comb begin
    w_next = r_state;
    w_stat = r_stat;
    case (r_state)
      ST_IDLE:    w_next = run ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        w_next = (imem_error || !instr_valid || icode == IHALT) ? ST_HALT : ST_DECODE;
        w_stat = imem_error ? S_ADR : !instr_valid ? S_INS : icode == IHALT ? S_HLT : r_stat;
      end
      ST_DECODE:  w_next = ST_EXECUTE;
      ST_EXECUTE: w_next = ST_MEMORY;
      ST_MEMORY: begin
        if (!w_mem_op || (mem_ready && !dmem_error)) w_next = ST_WB;
        else if (mem_ready || w_expired) begin
          w_next = ST_HALT;
          w_stat = S_ADR;
        end
      end
      ST_WB:      w_next = ST_PCUPD;
      ST_PCUPD:   w_next = run ? ST_FETCH : ST_IDLE;
      default:    w_next = r_state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_stat   <= S_AOK;
      r_icode  <= '0;
      r_pc     <= RESET_PC;
      r_cycles <= '0;
      r_instrs <= '0;
    end else begin
      r_state <= w_next;
      r_stat  <= w_stat;
      if (r_state == ST_FETCH) r_icode <= icode;
      if (r_state == ST_PCUPD) r_pc <= pc_next_in;
      if (r_state == ST_PCUPD && !(&r_instrs)) r_instrs <= r_instrs + 1'b1;
      if (w_busy && !(&r_cycles)) r_cycles <= r_cycles + 1'b1;
    end
  end
  assign pc          = r_pc;
  assign stat        = r_stat;
  assign halted      = r_state == ST_HALT;
  assign fetch_en    = r_state == ST_FETCH;
  assign decode_en   = r_state == ST_DECODE;
  assign execute_en  = r_state == ST_EXECUTE;
  assign memory_en   = r_state == ST_MEMORY;
  assign wb_en       = r_state == ST_WB;
  assign pcupd_en    = r_state == ST_PCUPD;
  assign cycle_count = r_cycles;
  assign instr_count = r_instrs;
endmodule

// File: tb/tb_seq_stage_controller.sv
// tb_seq_stage_controller: directed self-checking bench for seq_stage_controller
module tb_seq_stage_controller;
  logic        clk = 0, rst_n = 0, run = 0, instr_valid = 1, imem_error = 0;
  logic        mem_ready = 0, dmem_error = 0;
  logic [3:0]  icode = 4'h1;
  logic [63:0] pc_next_in = '0;
  logic [63:0] pc;
  logic        fetch_en, decode_en, execute_en, memory_en, wb_en, pcupd_en, halted;
  logic [2:0]  stat;
  logic [31:0] cycle_count, instr_count;
  logic [5:0]  en, seen;
  int          checks = 0, errors = 0;
  assign en = {fetch_en, decode_en, execute_en, memory_en, wb_en, pcupd_en};
  seq_stage_controller dut (
    .clk(clk), .rst_n(rst_n), .run(run), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .mem_ready(mem_ready), .dmem_error(dmem_error),
    .pc_next_in(pc_next_in), .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en),
    .execute_en(execute_en), .memory_en(memory_en), .wb_en(wb_en), .pcupd_en(pcupd_en),
    .stat(stat), .halted(halted), .cycle_count(cycle_count), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 0; run = 0; mem_ready = 0; dmem_error = 0; imem_error = 0; instr_valid = 1;
    tick;
    tick;
    rst_n = 1;
  endtask
  initial begin
    do_reset;
    repeat (10) tick;
    chk("rst_pc", pc, 0);
    chk("rst_stat", stat, 1);
    chk("rst_en", en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cyc", cycle_count, 0);
    chk("rst_ins", instr_count, 0);
    icode = 4'h1; pc_next_in = 64'h1; run = 1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("nop_en", en, 6'b100000 >> i);
      if (i == 5) begin
        chk("nop_pc_pre", pc, 0);
        run = 0;
      end
    end
    tick;
    chk("nop_pc", pc, 64'h1);
    chk("nop_ins", instr_count, 1);
    chk("nop_cyc", cycle_count, 6);
    chk("nop_idle", en, 0);
    icode = 4'h5; pc_next_in = 64'h20; run = 1;
    tick;
    chk("mr_f", en, 6'b100000);
    tick;
    tick;
    chk("mr_e", en, 6'b001000);
    run = 0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("mr_mem", en, 6'b000100);
      if (i == 4) mem_ready = 1;
    end
    tick;
    mem_ready = 0;
    chk("mr_wb", en, 6'b000010);
    tick;
    chk("mr_p", en, 6'b000001);
    chk("mr_pc_pre", pc, 64'h1);
    tick;
    chk("mr_pc", pc, 64'h20);
    chk("mr_ins", instr_count, 2);
    chk("mr_cyc", cycle_count, 15);
    chk("mr_idle", en, 0);
    pc_next_in = 64'h40; run = 1;
    tick;
    run = 0;
    tick;
    tick;
    for (int i = 1; i <= 15; i++) begin
      tick;
      chk("to_mem", en, 6'b000100);
    end
    tick;
    chk("to_stat", stat, 3);
    chk("to_halted", halted, 1);
    chk("to_pc", pc, 64'h20);
    chk("to_ins", instr_count, 2);
    chk("to_cyc", cycle_count, 33);
    chk("to_en", en, 0);
    do_reset;
    icode = 4'h0; run = 1;
    tick;
    tick;
    chk("hlt_stat", stat, 2);
    chk("hlt_halted", halted, 1);
    chk("hlt_pc", pc, 0);
    seen = '0;
    repeat (20) begin
      tick;
      seen |= en;
    end
    chk("hlt_quiet", seen, 0);
    chk("hlt_stays", halted, 1);
    do_reset;
    icode = 4'h1; instr_valid = 0; run = 1;
    tick;
    tick;
    chk("ins_stat", stat, 4);
    chk("ins_halted", halted, 1);
    chk("ins_count", instr_count, 0);
    do_reset;
    imem_error = 1; instr_valid = 0; run = 1;
    tick;
    tick;
    chk("imem_stat", stat, 3);
    do_reset;
    icode = 4'h5; run = 1;
    repeat (4) tick;
    chk("dm_mem", en, 6'b000100);
    mem_ready = 1; dmem_error = 1;
    tick;
    mem_ready = 0; dmem_error = 0;
    chk("dm_stat", stat, 3);
    chk("dm_halted", halted, 1);
    chk("dm_pc", pc, 0);
    chk("dm_ins", instr_count, 0);
    do_reset;
    icode = 4'h1; pc_next_in = 64'h55; run = 1;
    repeat (6) tick;
    icode = 4'h5;
    tick;
    chk("ar_pc_pre", pc, 64'h55);
    repeat (4) tick;
    chk("ar_mem", en, 6'b000100);
    #2;
    rst_n = 0;
    #1;
    chk("ar_en", en, 0);
    chk("ar_pc", pc, 0);
    chk("ar_cyc", cycle_count, 0);
    chk("ar_ins", instr_count, 0);
    chk("ar_stat", stat, 1);
    run = 0;
    tick;
    rst_n = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
